// File: rtl/uart_io_port.sv
// 8N1 UART on the I/O port bus: TX FIFO + serialiser, RX deserialiser + one-byte holding register; txd falls 2 edges after a write to an idle port.
// Writes to a full TX FIFO are dropped unless the serialiser pops that cycle; `UART_IO_LOOPBACK_EN` ties the RX input to the TX output.

module uart_io_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_push;

  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

module uart_io_port #(
  parameter int CLK_HZ   = 100000000,
  parameter int BAUD     = 115200,
  parameter int TX_DEPTH = 16
) (
  input  logic       clk100,
  input  logic       reset,
  input  logic [7:0] IO_port_ID,
  input  logic [7:0] IO_write_data,
  input  logic       IO_write_strobe,
  input  logic       IO_read_strobe,
  output logic [7:0] IO_read_data,
  input  logic       uart_rxd,
  output logic       uart_txd
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [7:0] PORT_DATA    = 8'h01;
  localparam logic [7:0] PORT_RX_STAT = 8'h02;
  localparam logic [7:0] PORT_TX_STAT = 8'h03;
  localparam logic [7:0] PORT_STATUS  = 8'h04;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic                      tx_push;
  logic                      rx_pop;
  logic                      sticky_clr;
  logic                      tx_pop;
  logic [7:0]                tx_head;
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic                      tx_full;
  logic                      tx_empty;

  assign tx_push    = IO_write_strobe && (IO_port_ID == PORT_DATA);
  assign rx_pop     = IO_read_strobe  && (IO_port_ID == PORT_DATA);
  assign sticky_clr = IO_read_strobe  && (IO_port_ID == PORT_STATUS);
  assign tx_full    = (tx_count == ($clog2(TX_DEPTH)+1)'(TX_DEPTH));
  assign tx_empty   = (tx_count == '0);

  uart_io_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
    .clk      (clk100),
    .reset    (reset),
    .push     (tx_push),
    .push_dat (IO_write_data),
    .pop      (tx_pop),
    .head     (tx_head),
    .count    (tx_count)
  );

  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;

  assign tx_pop = (tx_state == TX_IDLE) && !tx_empty;

  // uart_txd is registered from the current state, so the line trails the FSM by one edge.
  always_ff @(posedge clk100) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_txd <= 1'b1;
    end else begin
      case (tx_state)
        TX_START: uart_txd <= 1'b0;
        TX_DATA:  uart_txd <= tx_shift[0];
        default:  uart_txd <= 1'b1;
      endcase

      case (tx_state)
        TX_IDLE: begin
          if (!tx_empty) begin
            tx_shift <= tx_head;
            tx_cnt   <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= tx_bit + 1'b1;
            if (tx_bit == 3'd7) tx_state <= TX_STOP;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  logic rx_in;
`ifdef UART_IO_LOOPBACK_EN
  logic unused_rxd;
  assign rx_in      = uart_txd;
  assign unused_rxd = uart_rxd;
`else
  assign rx_in = uart_rxd;
`endif

  logic rx_meta;
  logic rx_sync;
  logic rx_prev;
  logic rx_fall;

  always_ff @(posedge clk100) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev && !rx_sync;

  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_done;
  logic          rx_ferr;

  always_ff @(posedge clk100) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_done  <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      rx_ferr <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          // Half a bit in: a line that is high again was only a glitch.
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) rx_done <= 1'b1;
            else         rx_ferr <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  logic [7:0] rx_hold;
  logic       rx_present;
  logic       overrun;
  logic       frame_err;

  // A pop and a delivery on the same edge: the pop frees the register first, so the new byte loads.
  always_ff @(posedge clk100) begin
    if (reset) begin
      rx_hold    <= '0;
      rx_present <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (sticky_clr) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (rx_ferr) frame_err <= 1'b1;
      if (rx_done) begin
        if (rx_present && !rx_pop) begin
          overrun <= 1'b1;
        end else begin
          rx_hold    <= rx_shift;
          rx_present <= 1'b1;
        end
      end else if (rx_pop) begin
        rx_present <= 1'b0;
      end
    end
  end

  always_comb begin
    IO_read_data = 8'h00;
    case (IO_port_ID)
      PORT_DATA:    IO_read_data = rx_hold;
      PORT_RX_STAT: IO_read_data = rx_present ? 8'hFF : 8'h00;
      PORT_TX_STAT: IO_read_data = tx_full ? 8'hFF : 8'h00;
      PORT_STATUS:  IO_read_data = {3'b000, frame_err, overrun, tx_empty, tx_full, rx_present};
      default:      IO_read_data = 8'h00;
    endcase
  end
endmodule

// File: doc/uart_io_port.md
# uart_io_port

Memory-mapped 8N1 UART peripheral on the processor's I/O port bus, directly downstream of `processor_top`. It consumes `IO_port_ID`, `IO_write_data`, `IO_write_strobe` and `IO_read_strobe`, and drives `IO_read_data` back into the core. It contains a TX FIFO feeding a serialiser and an RX deserialiser with a one-byte holding register. Status is exposed on fixed port IDs so firmware can poll for TX-full and RX-present.

## Interface
- `CLK_HZ`, 100000000: clock frequency in Hz.
- `BAUD`, 115200: line rate. `CLKS_PER_BIT = CLK_HZ/BAUD` (integer division; 868 at the defaults).
- `TX_DEPTH`, 16: TX FIFO depth. Must be a power of two, ≥ 2.
- `clk100`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `IO_port_ID`  in  8  port address for the current access.
- `IO_write_data`  in  8  write data.
- `IO_write_strobe`  in  1  one-cycle write qualifier.
- `IO_read_strobe`  in  1  one-cycle read qualifier.
- `IO_read_data`  out  8  read data, combinational from `IO_port_ID`.
- `uart_rxd`  in  1  asynchronous serial input; idle high.
- `uart_txd`  out  1  serial output; idle high.

## Operation
- Port map:
  - 0x01 write: push a byte into the TX FIFO.
  - 0x01 read: RX holding byte; pops it (clears rx_present).
  - 0x02 read: 8'hFF if rx_present, else 8'h00.
  - 0x03 read: 8'hFF if TX FIFO full, else 8'h00.
  - 0x04 read: {3'b0, frame_err, overrun, tx_empty, tx_full, rx_present}. The read clears both sticky bits, overrun and frame_err.
  - Unmapped reads return 8'h00. Unmapped writes are ignored.
- Side effects (pop, sticky clear, push) take place only on an edge where the matching strobe is high.
- TX FIFO:
  - Write while full is dropped, unless the serialiser pops in the same cycle; in that case the write is accepted.
  - Pointers wrap modulo `TX_DEPTH`.
  - Count is width log2(TX_DEPTH)+1.
- TX FSM: TX_IDLE → TX_START → TX_DATA (8 bits, LSB first) → TX_STOP → TX_IDLE.
  - TX_IDLE pops the FIFO head whenever the FIFO is non-empty.
  - Each bit lasts `CLKS_PER_BIT` cycles.
- RX path:
  - `uart_rxd` passes through a 2-flop synchroniser.
  - RX FSM: RX_IDLE → RX_START on a synchronised falling edge.
  - RX_START waits `CLKS_PER_BIT/2` cycles and re-samples. If the line is high, the event is a glitch and the FSM returns to RX_IDLE.
  - RX_DATA takes 8 samples, `CLKS_PER_BIT` apart, shifted in LSB first.
  - RX_STOP takes one sample. If high, the byte is delivered. If low, the byte is discarded, frame_err is set, and the FSM returns to RX_IDLE.
- Delivery when rx_present=1: the new byte is dropped, overrun is set, and the held byte is preserved.
- Delivery in the same cycle as a port-0x01 read: the pop is applied first, then the new byte loads, so rx_present stays 1.

## Timing
- Reset values:
  - `uart_txd`=1 and `IO_read_data` reflects the reset state.
  - FIFO empty, both FSMs idle, rx_present=0, overrun=0, frame_err=0, holding byte=8'h00.
- Reset mid-frame: `uart_txd`=1 from the next edge and queued bytes are lost. Reset during a partial RX frame discards it.
- TX latency: a write at edge N makes `uart_txd` go low at edge N+2, provided the FIFO was empty and TX was idle.
- Frame is exactly 10×`CLKS_PER_BIT` cycles.
- Back-to-back frames: the next start bit begins ≤1 cycle after the stop bit ends.
- RX latency: rx_present rises 1 cycle after the stop-bit sample. The stop-bit sample falls about 9.5 bit times + 3 cycles after the line's falling edge.
- tx_full and tx_empty reflect the FIFO count registered at the previous edge.

## Configuration
- `UART_IO_LOOPBACK_EN` defined:
  - The RX synchroniser input is internally tied to the TX serialiser output.
  - `uart_rxd` is ignored.
  - `uart_txd` still drives normally.
- Undefined: RX samples `uart_rxd`. No loopback logic is present.

## Test plan
- After reset: `uart_txd`=1. Reads of port 0x02 and port 0x03 return 8'h00. Port 0x04 returns 8'h04.
- Write 8'hA5 to port 0x01 → `uart_txd` low at write+2 edges. Bits 1,0,1,0,0,1,0,1 (LSB first) at 868-cycle spacing, then stop=1. Port 0x04 bit 2 returns to 1 after the pop.
- Write 17 bytes back-to-back, no pop window → port 0x03 reads 8'hFF after 16 queued. Exactly 17 frames on the line (1 popped early, 16 queued), or 16 if the first pop had not occurred. The bench checks the count against the pop cycle.
- Drive RX frame 8'h3C → port 0x02 reads 8'hFF and port 0x01 reads 8'h3C. Port 0x02 then reads 8'h00.
- Two RX frames 8'h11, 8'h22 without reading → port 0x01 reads 8'h11. Port 0x04 bit 3 = 1 on that read and clears on the following 0x04 read.
- RX frame with stop bit = 0 → no rx_present, port 0x04 bit 4 = 1. A 200-cycle low glitch causes no state change.
- With `UART_IO_LOOPBACK_EN`: write 8'h5A → port 0x01 reads 8'h5A after about 10 bit times.
